// File: rtl/wb_master_bridge_if.sv
// Bundle of signals between a local controller and a Wishbone B4 classic
// slave, as seen by wb_master_bridge.
//   command  : cmd_valid_i, cmd_ready_o, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i
//   response : rsp_valid_o, rsp_ready_i, rsp_dat_o, rsp_err_o
//   wishbone : adr_o, dat_o, dat_i, sel_o, we_o, stb_o, cyc_o, ack_i
// Signal names carry the bridge's point of view.
// Modport "master" is the bridge side. Modport "slave" is the environment side:
// the controller and the Wishbone slave.
interface wb_master_bridge_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid_i;
  logic                  cmd_ready_o;
  logic                  cmd_we_i;
  logic [ADDR_WIDTH-1:0] cmd_adr_i;
  logic [DATA_WIDTH-1:0] cmd_dat_i;
  logic [7:0]            cmd_sel_i;

  logic                  rsp_valid_o;
  logic                  rsp_ready_i;
  logic [DATA_WIDTH-1:0] rsp_dat_o;
  logic                  rsp_err_o;

  logic [ADDR_WIDTH-1:0] adr_o;
  logic [DATA_WIDTH-1:0] dat_o;
  logic [DATA_WIDTH-1:0] dat_i;
  logic [7:0]            sel_o;
  logic                  we_o;
  logic                  stb_o;
  logic                  cyc_o;
  logic                  ack_i;

  modport master (
    input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    input  rsp_ready_i, dat_i, ack_i,
    output cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    output adr_o, dat_o, sel_o, we_o, stb_o, cyc_o
  );

  modport slave (
    output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_dat_i, cmd_sel_i,
    output rsp_ready_i, dat_i, ack_i,
    input  cmd_ready_o, rsp_valid_o, rsp_dat_o, rsp_err_o,
    input  adr_o, dat_o, sel_o, we_o, stb_o, cyc_o
  );
endinterface

// File: rtl/wb_master_bridge.sv
// Wishbone B4 classic single-transfer master.
// It takes one command from a valid/ready port and runs one Wishbone read or
// write cycle. It then returns the outcome on a valid/ready response port.
//
// Ports:
//   clk_i  rising-edge clock
//   rst_i  synchronous, active-low reset
//   bus    wb_master_bridge_if.master (command, response and Wishbone signals)
//
// Optional build macro WB_MASTER_TIMEOUT_EN enables the bus-phase timeout.
// A cycle that gets no ack_i within TIMEOUT_CYCLES bus cycles is aborted.
// It then completes with rsp_err_o=1. Without the macro the bridge waits for
// ack_i indefinitely and rsp_err_o is tied to 0.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | cmd_ready_o high, waiting for cmd_valid_i
// BUS   | cyc_o/stb_o asserted, waiting for ack_i (or timeout)
// RESP  | rsp_valid_o asserted, waiting for rsp_ready_i
module wb_master_bridge #(
  parameter int ADDR_WIDTH     = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int GRANULE        = 8,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic               clk_i,
  input  logic               rst_i,
  wb_master_bridge_if.master bus
);

  localparam int LANES = DATA_WIDTH / GRANULE;
  // Select bits beyond the physical lane count are dropped.
  localparam logic [7:0] SEL_MASK = 8'((16'd1 << LANES) - 16'd1);

  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] adr_q;
  logic [DATA_WIDTH-1:0] dat_q;
  logic [7:0]            sel_q;
  logic                  we_q;
  logic                  stb_q;
  logic                  cyc_q;
  logic                  rsp_valid_q;
  logic [DATA_WIDTH-1:0] rsp_dat_q;
  logic [DATA_WIDTH-1:0] rd_mask;

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  // The count reaches TIMEOUT_CYCLES on the edge that ends the last allowed
  // bus cycle. That edge is the one where the count still holds TIMEOUT_CYCLES-1.
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  logic [TO_W-1:0] to_cnt;
  logic            rsp_err_q;
`endif

  // Expand the registered lane select into a bit mask for read data.
  always_comb begin
    rd_mask = '0;
    for (int i = 0; i < LANES; i++) begin
      rd_mask[i*GRANULE +: GRANULE] = {GRANULE{sel_q[i]}};
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      stb_q       <= 1'b0;
      cyc_q       <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_dat_q   <= '0;
`ifdef WB_MASTER_TIMEOUT_EN
      to_cnt      <= '0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid_i) begin
            adr_q <= bus.cmd_adr_i;
            dat_q <= bus.cmd_dat_i;
            sel_q <= bus.cmd_sel_i & SEL_MASK;
            we_q  <= bus.cmd_we_i;
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
            state <= BUS;
`ifdef WB_MASTER_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end
        end
        BUS: begin
          // ack_i has priority over a timeout that falls on the same edge.
          if (bus.ack_i) begin
            rsp_dat_q   <= we_q ? '0 : (bus.dat_i & rd_mask);
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= RESP;
`ifdef WB_MASTER_TIMEOUT_EN
            rsp_err_q   <= 1'b0;
          end else if (to_cnt == TO_LAST) begin
            rsp_dat_q   <= '0;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            we_q        <= 1'b0;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b1;
            state       <= RESP;
          end else begin
            to_cnt <= to_cnt + TO_W'(1);
`endif
          end
        end
        RESP: begin
          if (bus.rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cmd_ready_o = (state == IDLE);
  assign bus.adr_o       = adr_q;
  assign bus.dat_o       = dat_q;
  assign bus.sel_o       = sel_q;
  assign bus.we_o        = we_q;
  assign bus.stb_o       = stb_q;
  assign bus.cyc_o       = cyc_q;
  assign bus.rsp_valid_o = rsp_valid_q;
  assign bus.rsp_dat_o   = rsp_dat_q;
`ifdef WB_MASTER_TIMEOUT_EN
  assign bus.rsp_err_o   = rsp_err_q;
`else
  assign bus.rsp_err_o   = 1'b0;
`endif

endmodule

// File: doc/wb_master_bridge.md
Name: wb_master_bridge

Overview:
- Wishbone B4 classic single-transfer master; the initiator end of the bus that our register slaves respond to.
- Converts a simple valid/ready command port into one complete Wishbone read or write cycle.
- Returns the outcome on a valid/ready response port.
- Sits between a local controller or sequencer and a Wishbone slave or interconnect.

Parameters:
- ADDR_WIDTH, 16, address width of command and bus.
- DATA_WIDTH, 32, data width; one of 8/16/32/64.
- GRANULE, 8, byte-lane granularity; one of 8/16/32/64, not greater than DATA_WIDTH.
- TIMEOUT_CYCLES, 255, maximum bus-phase length in cycles; used only with WB_MASTER_TIMEOUT_EN; must be at least 2.

Ports:
- clk_i  in  1  Clock; all logic on the rising edge.
- rst_i  in  1  Reset, synchronous, active-low.
- cmd_valid_i  in  1  Command present.
- cmd_ready_o  out  1  Bridge can accept a command.
- cmd_we_i  in  1  1 = write, 0 = read.
- cmd_adr_i  in  ADDR_WIDTH  Command address.
- cmd_dat_i  in  DATA_WIDTH  Write data.
- cmd_sel_i  in  8  Lane select; bit i selects lane i.
- rsp_valid_o  out  1  Response present.
- rsp_ready_i  in  1  Consumer accepts the response.
- rsp_dat_o  out  DATA_WIDTH  Read data.
- rsp_err_o  out  1  Transfer aborted by timeout.
- adr_o  out  ADDR_WIDTH  Wishbone address.
- dat_o  out  DATA_WIDTH  Wishbone write data.
- dat_i  in  DATA_WIDTH  Wishbone read data.
- sel_o  out  8  Wishbone select.
- we_o  out  1  Wishbone write enable.
- stb_o  out  1  Wishbone strobe.
- cyc_o  out  1  Wishbone cycle.
- ack_i  in  1  Wishbone acknowledge.

Behaviour:
- Reset (rst_i low at an edge):
  - State becomes IDLE.
  - cyc_o, stb_o, we_o, rsp_valid_o and rsp_err_o become 0.
  - adr_o, dat_o, sel_o and rsp_dat_o become 0.
  - Reset wins over every other event.
  - Reset during BUS drops cyc_o/stb_o at that edge; the response is discarded.
  - Reset during RESP discards the pending response.
- All outputs are registered.
- cmd_ready_o = 1 exactly when the state is IDLE. It is combinational from state only, with no dependence on cmd_valid_i.
- State IDLE:
  - On cmd_valid_i=1, latch cmd_adr_i to adr_o, cmd_dat_i to dat_o and cmd_we_i to we_o.
  - Latch cmd_sel_i to sel_o with bits at index DATA_WIDTH/GRANULE and above forced to 0.
  - Set cyc_o=1 and stb_o=1, then go to BUS.
- State BUS:
  - cyc_o, stb_o, adr_o, dat_o, sel_o and we_o are held stable.
  - On ack_i=1 sampled at an edge:
    - Read: rsp_dat_o <= dat_i on selected lanes; unselected lanes <= 0.
    - Write: rsp_dat_o <= 0.
    - cyc_o, stb_o and we_o drop to 0 at that same edge.
    - rsp_valid_o <= 1 and rsp_err_o <= 0; go to RESP.
  - ack_i while not in BUS is ignored.
- State RESP:
  - rsp_valid_o, rsp_dat_o and rsp_err_o are held.
  - On rsp_ready_i=1, rsp_valid_o <= 0 and go to IDLE.
  - rsp_ready_i while rsp_valid_o=0 is ignored.
- stb_o is low for at least one full cycle between consecutive transfers; this lets a slave waiting for the phase end return to idle.
- Back-to-back throughput: with rsp_ready_i tied high and cmd_valid_i tied high, a new cycle starts no earlier than two edges after the previous ack.
- Latency against a two-cycle-ack slave:
  - Command accepted at edge N; stb_o high after N.
  - ack_i seen at N+3; rsp_valid_o high after N+3.
- Big-endian lane meaning is the slave's concern; the bridge passes data unaltered.

Optional Feature:
- Macro: WB_MASTER_TIMEOUT_EN.
- Defined:
  - A counter of $clog2(TIMEOUT_CYCLES+1) bits clears when BUS is entered and increments each BUS cycle without ack.
  - If it reaches TIMEOUT_CYCLES without ack_i, at that edge cyc_o/stb_o drop, rsp_err_o <= 1, rsp_dat_o <= 0, rsp_valid_o <= 1, and the state goes to RESP.
  - ack_i on the same edge as expiry takes precedence: normal completion, rsp_err_o=0.
- Not defined: no counter; BUS waits indefinitely; rsp_err_o is constant 0.

Test Plan:
- Write then read: write adr=0x0010, dat=0xDEADBEEF, sel=0x0F against a register slave, then read adr=0x0010 sel=0x0F -> write rsp_dat_o=0, rsp_err_o=0; read rsp_dat_o=0xDEADBEEF; stb_o held until ack each time.
- Partial select: read with sel=0x05 while the slave holds 0xAABBCCDD -> rsp_dat_o=0x00BB00DD; sel=0xF5 drives sel_o=0x05 (DATA_WIDTH=32).
- Response backpressure: rsp_ready_i low for 5 cycles after ack -> rsp_valid_o and rsp_dat_o stable; cmd_ready_o=0; no stb_o reassertion until after the rsp_ready_i handshake.
- Back-to-back: cmd_valid_i and rsp_ready_i held high for 3 writes -> exactly 3 ack-terminated cycles; stb_o low at least one cycle between each.
- Reset mid-cycle: rst_i low for 1 cycle while in BUS -> cyc_o=stb_o=0 next cycle, rsp_valid_o never pulses, and the next command completes normally.
- Timeout (WB_MASTER_TIMEOUT_EN, TIMEOUT_CYCLES=8): slave never acks -> cyc_o drops after 8 BUS cycles, rsp_err_o=1, rsp_dat_o=0; ack on cycle 8 instead yields rsp_err_o=0.
